// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch stage: sequential PC requests, prefetch FIFO, redirect flush
//
// Optional feature macro: INST_FETCH_ALIGN_CHECK_EN (adds the misalign output).
//
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   ir_addr_valid/ir_addr_ready/ir_addr  instruction bus request channel
//   ir_data_valid/ir_data_ready/ir_data  instruction bus response channel (in order)
//   inst_valid/inst_ready/inst/inst_pc   instruction + PC towards decode
//   redirect, redirect_pc                one-cycle restart request from execute
//   misalign                             (macro only) last redirect target was not word aligned
module inst_fetch #(
    parameter int                  inst_width = 32,
    parameter int                  pc_width   = 32,
    parameter logic [pc_width-1:0] reset_pc   = '0,
    parameter int                  fifo_depth = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  ir_addr_valid,
    input  logic                  ir_addr_ready,
    output logic [pc_width-1:0]   ir_addr,
    input  logic                  ir_data_valid,
    output logic                  ir_data_ready,
    input  logic [inst_width-1:0] ir_data,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [inst_width-1:0] inst,
    output logic [pc_width-1:0]   inst_pc,
    input  logic                  redirect,
    input  logic [pc_width-1:0]   redirect_pc
`ifdef INST_FETCH_ALIGN_CHECK_EN
    ,
    output logic                  misalign
`endif
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_t;

    localparam logic [2:0]          DEPTH_C = 3'(fifo_depth);
    localparam logic [pc_width-1:0] PC_STEP = pc_width'(4);

    state_t                state_q, state_d;
    logic [pc_width-1:0]   pc_q, pc_d;              // next address to present when no request is held
    logic                  held_q, held_d;          // request presented but not yet accepted
    logic [pc_width-1:0]   held_addr_q, held_addr_d;
    logic                  taint_q, taint_d;        // held request predates a redirect: drop its response
    logic [2:0]            discard_q, discard_d;
    logic [2:0]            q_count_q, q_count_d;    // outstanding requests
    logic [1:0]            q_head_q, q_head_d;
    logic [pc_width-1:0]   pcq_q [4];               // PCs of outstanding requests, request order
    logic [2:0]            f_count_q, f_count_d;
    logic [1:0]            f_head_q, f_head_d;
    logic [inst_width-1:0] f_inst_q [4];
    logic [pc_width-1:0]   f_pc_q [4];

    logic                  hold_issue;
    logic [pc_width-1:0]   redirect_tgt;
    logic [3:0]            credit_sum;
    logic                  issue_new, accept, drop, push, pop;
    logic [1:0]            q_tail, f_tail;

    // Circular pointer arithmetic for a depth that need not be a power of two.
    function automatic logic [1:0] wrap_add(input logic [1:0] base, input logic [2:0] off);
        logic [2:0] s;
        s = {1'b0, base} + off;
        if (s >= DEPTH_C) s = s - DEPTH_C;
        return s[1:0];
    endfunction

`ifdef INST_FETCH_ALIGN_CHECK_EN
    logic misalign_q, misalign_d;

    assign hold_issue   = misalign_q;
    assign misalign     = misalign_q;
    assign redirect_tgt = redirect_pc;

    always_comb begin
        misalign_d = misalign_q;
        if (redirect) misalign_d = (redirect_pc[1:0] != 2'b00);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) misalign_q <= 1'b0;
        else        misalign_q <= misalign_d;
    end
`else
    assign hold_issue   = 1'b0;
    assign redirect_tgt = redirect_pc & ~pc_width'(3);
`endif

    assign ir_data_ready = 1'b1;
    assign inst_valid    = (f_count_q != 3'd0);
    assign inst          = f_inst_q[f_head_q];
    assign inst_pc       = f_pc_q[f_head_q];

    always_comb begin
        // Credit counts outstanding requests plus buffered words so a response always has a slot.
        credit_sum    = {1'b0, q_count_q} + {1'b0, f_count_q};
        issue_new     = (state_q != IDLE) && !held_q && !hold_issue && (credit_sum < {1'b0, DEPTH_C});
        ir_addr_valid = held_q || issue_new;
        ir_addr       = held_q ? held_addr_q : pc_q;
        accept        = ir_addr_valid && ir_addr_ready;
        drop          = ir_data_valid && (discard_q != 3'd0);
        push          = ir_data_valid && !drop && !redirect;
        pop           = inst_valid && inst_ready && !redirect;
        q_tail        = wrap_add(q_head_q, q_count_q);
        f_tail        = wrap_add(f_head_q, f_count_q);

        q_count_d = q_count_q + {2'b00, accept} - {2'b00, ir_data_valid};
        q_head_d  = ir_data_valid ? wrap_add(q_head_q, 3'd1) : q_head_q;

        // pc_q advances as soon as an address is presented; a stalled one lives on in held_addr_q.
        pc_d        = pc_q;
        held_d      = held_q;
        held_addr_d = held_addr_q;
        taint_d     = taint_q;
        if (issue_new) pc_d = pc_q + PC_STEP;
        if (accept) begin
            held_d  = 1'b0;
            taint_d = 1'b0;
        end else if (issue_new) begin
            held_d      = 1'b1;
            held_addr_d = pc_q;
        end

        discard_d = discard_q;
        if (drop)             discard_d = discard_d - 3'd1;
        if (accept && taint_q) discard_d = discard_d + 3'd1;

        f_count_d = f_count_q + {2'b00, push} - {2'b00, pop};
        f_head_d  = pop ? wrap_add(f_head_q, 3'd1) : f_head_q;

        if (redirect) begin
            pc_d      = redirect_tgt;
            taint_d   = held_d;
            discard_d = q_count_d;
            f_count_d = 3'd0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = RUN;
            default: state_d = (discard_d != 3'd0) ? FLUSH : RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pc_q        <= reset_pc;
            held_q      <= 1'b0;
            held_addr_q <= '0;
            taint_q     <= 1'b0;
            discard_q   <= 3'd0;
            q_count_q   <= 3'd0;
            q_head_q    <= 2'd0;
            f_count_q   <= 3'd0;
            f_head_q    <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                pcq_q[i]    <= '0;
                f_inst_q[i] <= '0;
                f_pc_q[i]   <= '0;
            end
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            held_q      <= held_d;
            held_addr_q <= held_addr_d;
            taint_q     <= taint_d;
            discard_q   <= discard_d;
            q_count_q   <= q_count_d;
            q_head_q    <= q_head_d;
            f_count_q   <= f_count_d;
            f_head_q    <= f_head_d;
            if (accept) pcq_q[q_tail] <= ir_addr;
            if (push) begin
                f_inst_q[f_tail] <= ir_data;
                f_pc_q[f_tail]   <= pcq_q[q_head_q];
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst_n) assert (!(push && !pop && (f_count_q == DEPTH_C)));
    end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - self-checking bench for inst_fetch
module tb_inst_fetch;
    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ir_addr_valid, ir_addr_ready, ir_data_valid, ir_data_ready;
    logic [31:0] ir_addr, ir_data, inst, inst_pc, redirect_pc;
    logic        inst_valid, inst_ready, redirect;
`ifdef INST_FETCH_ALIGN_CHECK_EN
    logic        misalign;
`endif

    always #5 clk = ~clk;

    inst_fetch #(.inst_width(32), .pc_width(32), .reset_pc(RPC), .fifo_depth(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .ir_addr_valid(ir_addr_valid), .ir_addr_ready(ir_addr_ready), .ir_addr(ir_addr),
        .ir_data_valid(ir_data_valid), .ir_data_ready(ir_data_ready), .ir_data(ir_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
        .redirect(redirect), .redirect_pc(redirect_pc)
`ifdef INST_FETCH_ALIGN_CHECK_EN
        , .misalign(misalign)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: queues of outstanding requests and buffered PCs.
    typedef struct packed {
        logic [31:0] pc;
        logic        drop;
    } out_t;

    out_t        m_out[$];
    logic [31:0] m_fifo_pc[$];
    logic [31:0] bus_q[$];
    logic [31:0] m_next_pc, m_held_addr;
    bit          m_held, m_held_drop, m_started, m_mis;
    int          resp_pct;
    bit          e_avalid, e_ivalid;
    logic [31:0] e_addr, e_ipc, e_inst;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic model_reset();
        m_out.delete(); m_fifo_pc.delete(); bus_q.delete();
        m_next_pc = RPC; m_held = 0; m_held_drop = 0; m_held_addr = 0;
        m_started = 0; m_mis = 0;
    endtask

    task automatic model_expect();
        e_avalid = m_held || (m_started && !m_mis && (m_out.size() + m_fifo_pc.size() < DEPTH));
        e_addr   = m_held ? m_held_addr : m_next_pc;
        e_ivalid = (m_fifo_pc.size() > 0);
        e_ipc    = e_ivalid ? m_fifo_pc[0] : 32'h0;
        e_inst   = mem_word(e_ipc);
    endtask

    task automatic bus_drive();
        ir_data_valid = (bus_q.size() > 0) && ($urandom_range(99) < resp_pct);
        ir_data       = ir_data_valid ? mem_word(bus_q[0]) : $urandom;
    endtask

    task automatic model_advance();
        out_t        o;
        logic [31:0] tgt;
        o = '0;
        if (ir_data_valid) begin
            void'(bus_q.pop_front());
            o = m_out.pop_front();
        end
        if (e_ivalid && inst_ready && !redirect) void'(m_fifo_pc.pop_front());
        if (ir_data_valid && !o.drop && !redirect) m_fifo_pc.push_back(o.pc);
        if (e_avalid && ir_addr_ready) begin
            m_out.push_back(out_t'{pc: e_addr, drop: (m_held ? m_held_drop : 1'b0)});
            bus_q.push_back(e_addr);
            if (!m_held) m_next_pc = m_next_pc + 32'd4;
            m_held = 0;
        end else if (e_avalid && !m_held) begin
            m_held = 1; m_held_addr = m_next_pc; m_held_drop = 0;
            m_next_pc = m_next_pc + 32'd4;
        end
        if (redirect) begin
            m_fifo_pc.delete();
            foreach (m_out[i]) m_out[i].drop = 1'b1;
            if (m_held) m_held_drop = 1;
`ifdef INST_FETCH_ALIGN_CHECK_EN
            tgt   = redirect_pc;
            m_mis = (tgt[1:0] != 2'b00);
`else
            tgt = redirect_pc & ~32'd3;
`endif
            m_next_pc = tgt;
        end
        m_started = 1;
    endtask

    task automatic cycle_begin();
        bus_drive();
        #1;
        model_expect();
    endtask

    task automatic cycle_end();
        model_advance();
        @(negedge clk);
        redirect = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; ir_addr_ready = 0; ir_data_valid = 0; ir_data = 0;
        inst_ready = 0; redirect = 0; redirect_pc = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ir_addr_ready = 1; ir_data_valid = 0; ir_data = 0;
        inst_ready = 1; redirect = 0; redirect_pc = 0;
        repeat (2) @(negedge clk);
        #1;
        n_vec += 6;
        if (ir_addr_valid !== 1'b0) begin n_err++; $display("FAIL reset_addr_valid got %b exp 0", ir_addr_valid); end
        if (ir_addr !== RPC) begin n_err++; $display("FAIL reset_addr got %h exp %h", ir_addr, RPC); end
        if (inst_valid !== 1'b0) begin n_err++; $display("FAIL reset_inst_valid got %b exp 0", inst_valid); end
        if (inst !== 32'h0) begin n_err++; $display("FAIL reset_inst got %h exp 0", inst); end
        if (inst_pc !== 32'h0) begin n_err++; $display("FAIL reset_inst_pc got %h exp 0", inst_pc); end
        if (ir_data_ready !== 1'b1) begin n_err++; $display("FAIL reset_data_ready got %b exp 1", ir_data_ready); end
`ifdef INST_FETCH_ALIGN_CHECK_EN
        n_vec++;
        if (misalign !== 1'b0) begin n_err++; $display("FAIL reset_misalign got %b exp 0", misalign); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_vec++;
        if (ir_addr_valid !== 1'b0) begin n_err++; $display("FAIL idle_no_request got %b exp 0", ir_addr_valid); end
        @(negedge clk); #1;
        n_vec += 2;
        if (ir_addr_valid !== 1'b1) begin n_err++; $display("FAIL first_request_valid got %b exp 1", ir_addr_valid); end
        if (ir_addr !== RPC) begin n_err++; $display("FAIL first_request_addr got %h exp %h", ir_addr, RPC); end
    endtask

    task automatic test_stream();
        logic [31:0] popped[$];
        apply_reset();
        ir_addr_ready = 1; inst_ready = 1; resp_pct = 100;
        for (int c = 0; c < 20; c++) begin
            cycle_begin();
            n_vec += 2;
            if (ir_addr_valid !== e_avalid) begin n_err++; $display("FAIL stream_avalid c%0d got %b exp %b", c, ir_addr_valid, e_avalid); end
            if (inst_valid !== e_ivalid) begin n_err++; $display("FAIL stream_ivalid c%0d got %b exp %b", c, inst_valid, e_ivalid); end
            if (e_avalid) begin
                n_vec++;
                if (ir_addr !== e_addr) begin n_err++; $display("FAIL stream_addr c%0d got %h exp %h", c, ir_addr, e_addr); end
            end
            if (e_ivalid) begin
                n_vec++;
                if (inst !== e_inst) begin n_err++; $display("FAIL stream_inst c%0d got %h exp %h", c, inst, e_inst); end
            end
            if (c == 3) begin
                n_vec++;
                if (inst_valid !== 1'b1) begin n_err++; $display("FAIL stream_first_inst_cycle got %b exp 1", inst_valid); end
            end
            if (inst_valid && inst_ready) popped.push_back(inst_pc);
            cycle_end();
        end
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (popped.size() <= i) begin n_err++; $display("FAIL stream_order idx %0d got none exp %h", i, 32'(i * 4)); end
            else if (popped[i] !== 32'(i * 4)) begin n_err++; $display("FAIL stream_order idx %0d got %h exp %h", i, popped[i], 32'(i * 4)); end
        end
    endtask

    task automatic test_backpressure();
        int acc;
        apply_reset();
        ir_addr_ready = 1; inst_ready = 0; resp_pct = 100; acc = 0;
        for (int c = 0; c < 10; c++) begin
            cycle_begin();
            if (ir_addr_valid && ir_addr_ready) acc++;
            cycle_end();
        end
        #1;
        n_vec += 3;
        if (acc != DEPTH) begin n_err++; $display("FAIL bp_accepts got %0d exp %0d", acc, DEPTH); end
        if (ir_addr_valid !== 1'b0) begin n_err++; $display("FAIL bp_avalid_low got %b exp 0", ir_addr_valid); end
        if (inst_valid !== 1'b1) begin n_err++; $display("FAIL bp_fifo_full got %b exp 1", inst_valid); end
        @(negedge clk);
        inst_ready = 1;
        for (int c = 0; c < 8; c++) begin
            cycle_begin();
            n_vec += 2;
            if (ir_addr_valid !== e_avalid) begin n_err++; $display("FAIL bp_resume_avalid c%0d got %b exp %b", c, ir_addr_valid, e_avalid); end
            if (inst_valid && inst_pc !== e_ipc) begin n_err++; $display("FAIL bp_resume_pc c%0d got %h exp %h", c, inst_pc, e_ipc); end
            cycle_end();
        end
    endtask

    task automatic test_redirect_flush();
        bit          seen;
        logic [31:0] first_pc;
        apply_reset();
        ir_addr_ready = 1; inst_ready = 1; resp_pct = 0; seen = 0; first_pc = 0;
        for (int c = 0; c < 5; c++) begin cycle_begin(); cycle_end(); end
        redirect = 1; redirect_pc = 32'h100;
        cycle_begin(); cycle_end();
        resp_pct = 100;
        for (int c = 0; c < 12; c++) begin
            cycle_begin();
            if (c == 0) begin
                n_vec++;
                if (inst_valid !== 1'b0) begin n_err++; $display("FAIL flush_no_stale got %b exp 0", inst_valid); end
            end
            n_vec++;
            if (inst_valid !== e_ivalid) begin n_err++; $display("FAIL flush_ivalid c%0d got %b exp %b", c, inst_valid, e_ivalid); end
            if (inst_valid && !seen) begin seen = 1; first_pc = inst_pc; end
            cycle_end();
        end
        n_vec++;
        if (!seen || first_pc !== 32'h100) begin n_err++; $display("FAIL flush_first_pc got %h exp 00000100", first_pc); end
    endtask

    task automatic test_held_redirect();
        bit          have, seen;
        logic [31:0] stall_addr, first_pc;
        apply_reset();
        ir_addr_ready = 1; inst_ready = 1; resp_pct = 100;
        have = 0; seen = 0; stall_addr = 0; first_pc = 0;
        for (int c = 0; c < 4; c++) begin cycle_begin(); cycle_end(); end
        ir_addr_ready = 0;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin redirect = 1; redirect_pc = 32'h40; end
            cycle_begin();
            if (have) begin
                n_vec += 2;
                if (ir_addr_valid !== 1'b1) begin n_err++; $display("FAIL held_valid c%0d got %b exp 1", c, ir_addr_valid); end
                if (ir_addr !== stall_addr) begin n_err++; $display("FAIL held_addr c%0d got %h exp %h", c, ir_addr, stall_addr); end
            end else if (e_avalid) begin
                have = 1; stall_addr = e_addr;
            end
            cycle_end();
        end
        ir_addr_ready = 1;
        for (int c = 0; c < 15; c++) begin
            cycle_begin();
            if (c == 0) begin
                n_vec++;
                if (ir_addr !== stall_addr) begin n_err++; $display("FAIL held_addr_accept got %h exp %h", ir_addr, stall_addr); end
            end
            if (inst_valid && !seen) begin seen = 1; first_pc = inst_pc; end
            cycle_end();
        end
        n_vec++;
        if (!seen || first_pc !== 32'h40) begin n_err++; $display("FAIL held_first_pc got %h exp 00000040", first_pc); end
    endtask

    task automatic test_wrap();
        logic [31:0] accs[$];
        apply_reset();
        ir_addr_ready = 1; inst_ready = 1; resp_pct = 100;
        for (int c = 0; c < 5; c++) begin cycle_begin(); cycle_end(); end
        redirect = 1; redirect_pc = 32'hFFFF_FFFC;
        cycle_begin(); cycle_end();
        for (int c = 0; c < 10; c++) begin
            cycle_begin();
            if (ir_addr_valid && ir_addr_ready) accs.push_back(ir_addr);
            cycle_end();
        end
        n_vec += 2;
        if (accs.size() < 2) begin n_err++; $display("FAIL wrap_requests got %0d exp >=2", accs.size()); end
        else begin
            if (accs[0] !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_first got %h exp fffffffc", accs[0]); end
            if (accs[1] !== 32'h0000_0000) begin n_err++; $display("FAIL wrap_second got %h exp 00000000", accs[1]); end
        end
    endtask

`ifdef INST_FETCH_ALIGN_CHECK_EN
    task automatic test_misalign();
        logic [31:0] accs[$];
        apply_reset();
        ir_addr_ready = 1; inst_ready = 1; resp_pct = 100;
        for (int c = 0; c < 5; c++) begin cycle_begin(); cycle_end(); end
        redirect = 1; redirect_pc = 32'h102;
        cycle_begin(); cycle_end();
        for (int c = 0; c < 8; c++) begin
            cycle_begin();
            n_vec += 2;
            if (misalign !== 1'b1) begin n_err++; $display("FAIL mis_set c%0d got %b exp 1", c, misalign); end
            if (ir_addr_valid !== 1'b0) begin n_err++; $display("FAIL mis_no_req c%0d got %b exp 0", c, ir_addr_valid); end
            cycle_end();
        end
        redirect = 1; redirect_pc = 32'h200;
        cycle_begin(); cycle_end();
        for (int c = 0; c < 6; c++) begin
            cycle_begin();
            n_vec++;
            if (misalign !== 1'b0) begin n_err++; $display("FAIL mis_clear c%0d got %b exp 0", c, misalign); end
            if (ir_addr_valid && ir_addr_ready) accs.push_back(ir_addr);
            cycle_end();
        end
        n_vec++;
        if (accs.size() < 1 || accs[0] !== 32'h200) begin n_err++; $display("FAIL mis_resume got %0d reqs exp first 00000200", accs.size()); end
    endtask
`endif

    task automatic test_random();
        apply_reset();
        resp_pct = 60;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(999) == 0) begin
                apply_reset();
                resp_pct = 60;
            end
            ir_addr_ready = ($urandom_range(99) < 70);
            inst_ready    = ($urandom_range(99) < 70);
            redirect      = ($urandom_range(99) < 5);
            redirect_pc   = ($urandom_range(9) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                                     : ($urandom & 32'h0000_FFFF);
            cycle_begin();
            n_vec += 3;
            if (ir_addr_valid !== e_avalid) begin n_err++; $display("FAIL rnd_avalid c%0d got %b exp %b", c, ir_addr_valid, e_avalid); end
            if (inst_valid !== e_ivalid) begin n_err++; $display("FAIL rnd_ivalid c%0d got %b exp %b", c, inst_valid, e_ivalid); end
            if (ir_data_ready !== 1'b1) begin n_err++; $display("FAIL rnd_data_ready c%0d got %b exp 1", c, ir_data_ready); end
            if (e_avalid) begin
                n_vec++;
                if (ir_addr !== e_addr) begin n_err++; $display("FAIL rnd_addr c%0d got %h exp %h", c, ir_addr, e_addr); end
            end
            if (e_ivalid) begin
                n_vec += 2;
                if (inst_pc !== e_ipc) begin n_err++; $display("FAIL rnd_inst_pc c%0d got %h exp %h", c, inst_pc, e_ipc); end
                if (inst !== e_inst) begin n_err++; $display("FAIL rnd_inst c%0d got %h exp %h", c, inst, e_inst); end
            end
`ifdef INST_FETCH_ALIGN_CHECK_EN
            n_vec++;
            if (misalign !== m_mis) begin n_err++; $display("FAIL rnd_misalign c%0d got %b exp %b", c, misalign, m_mis); end
`endif
            cycle_end();
        end
    endtask

    initial begin
        ir_addr_ready = 0; ir_data_valid = 0; ir_data = 0; inst_ready = 0;
        redirect = 0; redirect_pc = 0; resp_pct = 100;
        model_reset();
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_flush();
        test_held_redirect();
        test_wrap();
`ifdef INST_FETCH_ALIGN_CHECK_EN
        test_misalign();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
